imem_fetch_q: RTL and testbench

- Parametrised instruction memory with a multi-instruction fetch port and a registered response path backed by a skid buffer.
- Sits between the fetch/PC stage and decode/issue.
- Returns FETCH_W consecutive instruction words per accepted request, using valid/ready handshakes on both sides.
- Provides a program-load write port, a flush for branch redirects, and a 1-cycle read latency.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_fetch_q_if.sv | 36 +++
 rtl/imem_skid.sv | 81 ++++++++
 rtl/imem_fetch_q.sv | 90 +++++++++
 tb/tb_imem_fetch_q.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-fetch queue.
// The optional IMEM_RANGE_CHECK_EN build adds a registered resp_fault flag.
package imem_pkg;

  localparam logic [31:0] NOP_INST   = 32'd0;
  localparam int          ADDR_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } occ_state_e;

  // Byte address to word index; callers truncate to their array depth.
  function automatic logic [ADDR_MAX_W-1:0] word_index(input logic [ADDR_MAX_W-1:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/imem_fetch_q_if.sv
// Fetch request/response handshake bundle between the PC stage and decode.
// Under IMEM_RANGE_CHECK_EN the response carries a resp_fault flag.
interface imem_fetch_q_if #(
  parameter int FETCH_W = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32
);

  logic                      req_valid;
  logic [ADDR_W-1:0]         req_addr;
  logic                      req_ready;
  logic                      resp_valid;
  logic [FETCH_W*DATA_W-1:0] resp_inst;
  logic [ADDR_W-1:0]         resp_addr;
  logic                      resp_ready;
`ifdef IMEM_RANGE_CHECK_EN
  logic                      resp_fault;
`endif

  modport master (
    output req_valid, req_addr, resp_ready,
`ifdef IMEM_RANGE_CHECK_EN
    input  resp_fault,
`endif
    input  req_ready, resp_valid, resp_inst, resp_addr
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
`ifdef IMEM_RANGE_CHECK_EN
    output resp_fault,
`endif
    output req_ready, resp_valid, resp_inst, resp_addr
  );

endinterface

// File: rtl/imem_skid.sv
// One-entry skid buffer behind an output register; occupancy is the state.
// Ready depends only on registered state, so there is no path from o_pop_ready.
module imem_skid
  import imem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop_ready,
  output logic         o_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data
);

  occ_state_e   r_state;
  logic [W-1:0] r_out;
  logic [W-1:0] r_skid;
  logic         w_pop;

  assign w_pop = (r_state != ST_EMPTY) && i_pop_ready;

  // NOTE: state and data registers use non-blocking assignments so every
  // branch sees the pre-edge values of r_out/r_skid regardless of order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_out   <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_skid <= '0;
      if (i_push) begin
        r_state <= ST_ONE;
        r_out   <= i_data;
      end else begin
        r_state <= ST_EMPTY;
        r_out   <= '0;
      end
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (i_push) begin
            r_state <= ST_ONE;
            r_out   <= i_data;
          end
        end
        ST_ONE: begin
          if (i_push && w_pop) begin
            r_out <= i_data;
          end else if (i_push) begin
            r_skid  <= i_data;
            r_state <= ST_FULL;
          end else if (w_pop) begin
            r_out   <= '0;
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            r_out   <= r_skid;
            r_skid  <= '0;
            r_state <= ST_ONE;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_out   <= '0;
          r_skid  <= '0;
        end
      endcase
    end
  end

  assign o_valid = (r_state != ST_EMPTY);
  assign o_ready = (r_state != ST_FULL);
  assign o_data  = r_out;

endmodule

// File: rtl/imem_fetch_q.sv
// Instruction memory returning FETCH_W consecutive words per request, 1-cycle latency.
// Define IMEM_RANGE_CHECK_EN to flag out-of-range/misaligned fetches via resp_fault.
module imem_fetch_q
  import imem_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int FETCH_W = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_fetch_q_if.slave     bus,
  input  logic              flush,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int INST_W = FETCH_W * DATA_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0]  w_req_idx;
  logic [IDX_W-1:0]  w_ld_idx;
  logic [IDX_W-1:0]  w_lane_idx [FETCH_W];
  logic [INST_W-1:0] w_lanes;
  logic [INST_W-1:0] w_rd_inst;
  logic              w_accept;

  assign w_req_idx = IDX_W'(word_index(ADDR_MAX_W'(bus.req_addr)));
  assign w_ld_idx  = IDX_W'(word_index(ADDR_MAX_W'(ld_addr)));
  assign w_accept  = bus.req_valid && bus.req_ready;

  // NOTE: the instruction array has no reset; program contents survive rst_n.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      r_mem[w_ld_idx] <= ld_data;
    end
  end

  // Lane indices wrap naturally because they are IDX_W bits wide.
  for (genvar k = 0; k < FETCH_W; k++) begin : g_lane
    assign w_lane_idx[k]                = w_req_idx + IDX_W'(k);
    assign w_lanes[k*DATA_W +: DATA_W]  = r_mem[w_lane_idx[k]];
  end

`ifdef IMEM_RANGE_CHECK_EN
  localparam int PAY_W = INST_W + ADDR_W + 1;

  logic [ADDR_MAX_W:0] w_last_word;
  logic                w_fault;
  logic [PAY_W-1:0]    w_push_data;
  logic [PAY_W-1:0]    w_pop_data;

  assign w_last_word = {1'b0, word_index(ADDR_MAX_W'(bus.req_addr))}
                     + (ADDR_MAX_W+1)'(FETCH_W - 1);
  assign w_fault     = (w_last_word >= (ADDR_MAX_W+1)'(DEPTH))
                    || (bus.req_addr[1:0] != 2'b00);
  assign w_rd_inst   = w_fault ? {FETCH_W{DATA_W'(NOP_INST)}} : w_lanes;
  assign w_push_data = {w_fault, bus.req_addr, w_rd_inst};
  assign {bus.resp_fault, bus.resp_addr, bus.resp_inst} = w_pop_data;
`else
  localparam int PAY_W = INST_W + ADDR_W;

  logic [PAY_W-1:0] w_push_data;
  logic [PAY_W-1:0] w_pop_data;

  assign w_rd_inst   = w_lanes;
  assign w_push_data = {bus.req_addr, w_rd_inst};
  assign {bus.resp_addr, bus.resp_inst} = w_pop_data;
`endif

  // Capturing the async array read into OUT/SKID gives the synchronous,
  // read-first behaviour: a same-edge load is not yet visible.
  imem_skid #(
    .W (PAY_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .i_push      (w_accept),
    .i_data      (w_push_data),
    .i_pop_ready (bus.resp_ready),
    .o_valid     (bus.resp_valid),
    .o_ready     (bus.req_ready),
    .o_data      (w_pop_data)
  );

endmodule

// File: tb/tb_imem_fetch_q.sv
// Self-checking bench for imem_fetch_q: directed vector table plus randomized
// traffic against a queue-based reference model (IMEM_RANGE_CHECK_EN aware).
module tb_imem_fetch_q;

  localparam int DEPTH   = 128;
  localparam int FETCH_W = 2;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam logic [31:0] WRAP_A = 32'((DEPTH - 1) * 4);

  typedef struct {
    logic        req_v;
    logic [31:0] addr;
    logic        rdy;
    logic        fl;
    logic        we;
    logic [31:0] ld_a;
    logic [31:0] ld_d;
    logic        rst_n;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        e_v;
    logic        e_r;
    logic [31:0] e_l0;
    logic [31:0] e_l1;
    logic [31:0] e_a;
    logic        e_f;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] inst;
    logic        fault;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  always #5 clk = ~clk;

  imem_fetch_q_if #(.FETCH_W(FETCH_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  imem_fetch_q #(
    .DEPTH   (DEPTH),
    .FETCH_W (FETCH_W),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .flush   (flush),
    .ld_we   (ld_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  logic [31:0] shadow [DEPTH];
  resp_t       q [$];
  vec_t        vecs [$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic stim_t st(input bit req_v, input logic [31:0] addr, input bit rdy,
                               input bit fl, input bit we, input logic [31:0] ld_a,
                               input logic [31:0] ld_d, input bit rst);
    stim_t s;
    s.req_v = req_v; s.addr = addr; s.rdy = rdy; s.fl = fl;
    s.we = we; s.ld_a = ld_a; s.ld_d = ld_d; s.rst_n = rst;
    return s;
  endfunction

  function automatic vec_t vx(input stim_t s, input bit e_v, input bit e_r,
                              input logic [31:0] l0, input logic [31:0] l1,
                              input logic [31:0] a, input bit f);
    vec_t v;
    v.s = s; v.e_v = e_v; v.e_r = e_r; v.e_l0 = l0; v.e_l1 = l1; v.e_a = a; v.e_f = f;
    return v;
  endfunction

  // Expected response for a fetch, taken from the shadow image before any same-edge load.
  function automatic resp_t model_read(input logic [31:0] addr);
    resp_t r;
    int    idx;
    idx     = int'((addr >> 2) % DEPTH);
    r.addr  = addr;
    r.fault = 1'b0;
    for (int k = 0; k < FETCH_W; k++) r.inst[k*32 +: 32] = shadow[(idx + k) % DEPTH];
`ifdef IMEM_RANGE_CHECK_EN
    if ((addr[1:0] != 2'b00) || (longint'(addr >> 2) + FETCH_W - 1 >= DEPTH)) begin
      r.fault = 1'b1;
      r.inst  = '0;
    end
`endif
    return r;
  endfunction

  // Drive one cycle of stimulus and advance the model as an ordered queue of responses.
  task automatic apply(input stim_t s);
    bit    acc;
    bit    pop;
    resp_t e;
    bus.req_valid  = s.req_v;
    bus.req_addr   = s.addr;
    bus.resp_ready = s.rdy;
    flush          = s.fl;
    ld_we          = s.we;
    ld_addr        = s.ld_a;
    ld_data        = s.ld_d;
    rst_n          = s.rst_n;
    acc = s.req_v && (q.size() < 2);
    pop = (q.size() > 0) && s.rdy;
    e   = model_read(s.addr);
    @(posedge clk);
    if (!s.rst_n) q.delete();
    else begin
      if (s.fl) q.delete();
      else if (pop) q.delete(0);
      if (acc) q.push_back(e);
    end
    if (s.we) shadow[(s.ld_a >> 2) % DEPTH] = s.ld_d;
    #1;
  endtask

  task automatic model_check(input int cyc);
    bit ev;
    ev = (q.size() > 0);
    check($sformatf("r%0d_valid", cyc), 64'(bus.resp_valid), 64'(ev));
    check($sformatf("r%0d_ready", cyc), 64'(bus.req_ready), 64'(q.size() < 2));
    if (ev) begin
      check($sformatf("r%0d_inst", cyc), bus.resp_inst, q[0].inst);
      check($sformatf("r%0d_addr", cyc), 64'(bus.resp_addr), 64'(q[0].addr));
`ifdef IMEM_RANGE_CHECK_EN
      check($sformatf("r%0d_fault", cyc), 64'(bus.resp_fault), 64'(q[0].fault));
`endif
    end else begin
      check($sformatf("r%0d_inst_idle", cyc), bus.resp_inst, 64'd0);
      check($sformatf("r%0d_addr_idle", cyc), 64'(bus.resp_addr), 64'd0);
    end
  endtask

  initial begin
    stim_t s;

    // inputs: req_v, addr, rdy, fl, we, ld_a, ld_d, rst_n -> valid, ready, lane0, lane1, addr, fault
    vecs.push_back(vx(st(0, 0,  1, 0, 0, 0, 0, 0),            0, 1, 0, 0, 0, 0));
    vecs.push_back(vx(st(0, 0,  1, 0, 1, 0, 32'h11, 1),       0, 1, 0, 0, 0, 0));
    vecs.push_back(vx(st(0, 0,  1, 0, 1, 4, 32'h22, 1),       0, 1, 0, 0, 0, 0));
    vecs.push_back(vx(st(0, 0,  1, 0, 1, 8, 32'h33, 1),       0, 1, 0, 0, 0, 0));
    vecs.push_back(vx(st(0, 0,  1, 0, 1, 12, 32'h44, 1),      0, 1, 0, 0, 0, 0));
    vecs.push_back(vx(st(0, 0,  1, 0, 1, WRAP_A, 32'h7F, 1),  0, 1, 0, 0, 0, 0));
    vecs.push_back(vx(st(1, 0,  1, 0, 0, 0, 0, 1),            1, 1, 32'h11, 32'h22, 0, 0));
    vecs.push_back(vx(st(0, 0,  1, 0, 0, 0, 0, 1),            0, 1, 0, 0, 0, 0));
    // back-pressure: fill to FULL, hold, then drain in order
    vecs.push_back(vx(st(1, 0,  0, 0, 0, 0, 0, 1),            1, 1, 32'h11, 32'h22, 0, 0));
    vecs.push_back(vx(st(1, 8,  0, 0, 0, 0, 0, 1),            1, 0, 32'h11, 32'h22, 0, 0));
    vecs.push_back(vx(st(1, 8,  0, 0, 0, 0, 0, 1),            1, 0, 32'h11, 32'h22, 0, 0));
    vecs.push_back(vx(st(0, 0,  1, 0, 0, 0, 0, 1),            1, 1, 32'h33, 32'h44, 8, 0));
    vecs.push_back(vx(st(0, 0,  1, 0, 0, 0, 0, 1),            0, 1, 0, 0, 0, 0));
    // wrap at top of memory
`ifdef IMEM_RANGE_CHECK_EN
    vecs.push_back(vx(st(1, WRAP_A, 1, 0, 0, 0, 0, 1),        1, 1, 0, 0, WRAP_A, 1));
`else
    vecs.push_back(vx(st(1, WRAP_A, 1, 0, 0, 0, 0, 1),        1, 1, 32'h7F, 32'h11, WRAP_A, 0));
`endif
    vecs.push_back(vx(st(0, 0,  1, 0, 0, 0, 0, 1),            0, 1, 0, 0, 0, 0));
    // flush while FULL (request refused), then flush in ONE with an accepted request
    vecs.push_back(vx(st(1, 0,  0, 0, 0, 0, 0, 1),            1, 1, 32'h11, 32'h22, 0, 0));
    vecs.push_back(vx(st(1, 4,  0, 0, 0, 0, 0, 1),            1, 0, 32'h11, 32'h22, 0, 0));
    vecs.push_back(vx(st(1, 8,  0, 1, 0, 0, 0, 1),            0, 1, 0, 0, 0, 0));
    vecs.push_back(vx(st(1, 8,  0, 0, 0, 0, 0, 1),            1, 1, 32'h33, 32'h44, 8, 0));
    vecs.push_back(vx(st(1, 0,  0, 1, 0, 0, 0, 1),            1, 1, 32'h11, 32'h22, 0, 0));
    vecs.push_back(vx(st(0, 0,  1, 0, 0, 0, 0, 1),            0, 1, 0, 0, 0, 0));
    // read-during-write returns old data, next read sees the new word
    vecs.push_back(vx(st(1, 4,  1, 0, 1, 4, 32'hAB, 1),       1, 1, 32'h22, 32'h33, 4, 0));
    vecs.push_back(vx(st(1, 4,  1, 0, 0, 0, 0, 1),            1, 1, 32'hAB, 32'h33, 4, 0));
    vecs.push_back(vx(st(0, 0,  1, 0, 0, 0, 0, 1),            0, 1, 0, 0, 0, 0));
    // reset while FULL, memory retained
    vecs.push_back(vx(st(1, 0,  0, 0, 0, 0, 0, 1),            1, 1, 32'h11, 32'hAB, 0, 0));
    vecs.push_back(vx(st(1, 8,  0, 0, 0, 0, 0, 1),            1, 0, 32'h11, 32'hAB, 0, 0));
    vecs.push_back(vx(st(0, 0,  0, 0, 0, 0, 0, 0),            0, 1, 0, 0, 0, 0));
    vecs.push_back(vx(st(1, 0,  1, 0, 0, 0, 0, 1),            1, 1, 32'h11, 32'hAB, 0, 0));
    vecs.push_back(vx(st(0, 0,  1, 0, 0, 0, 0, 1),            0, 1, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].s);
      check($sformatf("v%0d_valid", i), 64'(bus.resp_valid), 64'(vecs[i].e_v));
      check($sformatf("v%0d_ready", i), 64'(bus.req_ready), 64'(vecs[i].e_r));
      check($sformatf("v%0d_inst", i), bus.resp_inst, {vecs[i].e_l1, vecs[i].e_l0});
      check($sformatf("v%0d_addr", i), 64'(bus.resp_addr), 64'(vecs[i].e_a));
`ifdef IMEM_RANGE_CHECK_EN
      check($sformatf("v%0d_fault", i), 64'(bus.resp_fault), 64'(vecs[i].e_f));
`endif
    end

    // Fill the whole array so every random fetch reads defined data.
    for (int i = 0; i < DEPTH; i++) begin
      apply(st(0, 0, 1, 0, 1, 32'(i * 4), $urandom, 1));
      model_check(i);
    end

    for (int i = 0; i < 800; i++) begin
      s.req_v = ($urandom_range(0, 9) < 7);
      s.addr  = $urandom_range(0, DEPTH * 4 + 7);
      s.rdy   = ($urandom_range(0, 9) < 6);
      s.fl    = ($urandom_range(0, 19) == 0);
      s.we    = ($urandom_range(0, 4) == 0);
      s.ld_a  = $urandom_range(0, DEPTH * 4 - 1);
      s.ld_d  = $urandom;
      s.rst_n = ($urandom_range(0, 49) != 0);
      apply(s);
      model_check(DEPTH + i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
